// File: rtl/hdmi_fetch_pkg.sv
// Shared definitions for the HDMI pixel fetcher: the FSM state type, the
// default parameter values and the line-length helper.
package hdmi_fetch_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, REQ, XFER, DRAIN} fetch_state_t;

  localparam int unsigned DEF_FIFO_DEPTH      = 256;
  localparam int unsigned DEF_CHUNK_WORDS     = 64;
  localparam int unsigned DEF_PREFETCH_CHUNKS = 2;
  localparam int unsigned DEF_ADDR_W          = 32;

  // 32-bit frame-buffer words per line: one pixel per word for RGB888,
  // two pixels per word (rounded up) for RGB565.
  function automatic logic [10:0] words_per_line(input logic [10:0] hres,
                                                 input logic        rgb888);
    logic [11:0] h1;
    h1 = {1'b0, hres} + 12'd1;
    return rgb888 ? hres : h1[11:1];
  endfunction

endpackage

// File: rtl/hdmi_pixel_fetch_if.sv
// Memory burst-read bus used by the HDMI pixel fetcher.
//   master (fetcher): drives rd_req, rd_addr, rd_len; receives rd_ack and data beats
//   slave  (memory) : accepts requests, returns rd_data/rd_data_valid (no backpressure)
interface hdmi_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              rd_ack;
  logic [31:0]       rd_data;
  logic              rd_data_valid;

  modport master (output rd_req, rd_addr, rd_len,
                  input  rd_ack, rd_data, rd_data_valid);
  modport slave  (input  rd_req, rd_addr, rd_len,
                  output rd_ack, rd_data, rd_data_valid);
endinterface

// File: rtl/hdmi_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO for 32-bit pixel words.
// Ports: clock, reset (sync, active-high), flush (sync clear), push/push_data,
//   pop, head (front word or EMPTY_WORD when empty), empty, count (words held).
// A word pushed at edge N reaches the output register at edge N+1.
module hdmi_pixel_fifo #(
  parameter int unsigned DEPTH      = 256,
  parameter logic [31:0] EMPTY_WORD = '0,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [31:0]   head,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_count;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          load;

  // Refill the output register whenever it is free or being popped.
  assign load = (mem_count != '0) && (!out_valid || pop);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      case ({push, load})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
    if (load) out_data <= mem[rd_ptr];
  end

  assign head  = out_valid ? out_data : EMPTY_WORD;
  assign empty = !out_valid;
  assign count = mem_count + CW'(out_valid);

endmodule

// File: rtl/hdmi_pixel_fetch.sv
// HDMI pixel fetcher: reads frame-buffer lines from memory in credit-paced
// bursts and buffers them in a FWFT FIFO popped by the HDMI core.
// Ports: clock, reset (sync, active-high), start (low = abort), frame_base,
//   hres, num_bytes_per_pixel (1=RGB888, 0=RGB565), read_go/read_next_line/
//   read_next_chunk/read_done strobes, read_fifo/color (FIFO head),
//   mem (burst read bus, master side), underflow (sticky empty-pop flag).
// Optional: define HDMI_FETCH_UNDERFLOW_CNT_EN to add underflow_count[15:0].
module hdmi_pixel_fetch
  import hdmi_fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int unsigned CHUNK_WORDS     = DEF_CHUNK_WORDS,
  parameter int unsigned PREFETCH_CHUNKS = DEF_PREFETCH_CHUNKS,
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter logic [31:0] UNDERFLOW_COLOR = 32'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [10:0]       hres,
  input  logic              num_bytes_per_pixel,
  input  logic              read_go,
  input  logic              read_next_line,
  input  logic              read_next_chunk,
  input  logic              read_done,
  input  logic              read_fifo,
  output logic [31:0]       color,
  hdmi_pixel_fetch_if.master mem,
  output logic              underflow
`ifdef HDMI_FETCH_UNDERFLOW_CNT_EN
  , output logic [15:0]     underflow_count
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  CREDIT_INIT = 8'(PREFETCH_CHUNKS);
  localparam logic [7:0]  CREDIT_MAX  = 8'(2 * PREFETCH_CHUNKS);

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] row_addr, cur_addr, stride, row_next;
  logic [10:0]       words_left, line_words;
  logic [7:0]        credit, credit_nx, beats, chunk_len;
  logic              line_pend;
  logic              fifo_push, fifo_flush, fifo_empty;
  logic [CW-1:0]     fifo_count, fifo_free;
  logic              abort, acked, can_issue, issue, take_ack, active, load_now, pop_empty;

  assign line_words = words_per_line(hres, num_bytes_per_pixel);
  assign stride     = ADDR_W'({line_words, 2'b00});
  assign row_next   = row_addr + stride;
  assign chunk_len  = (words_left >= 11'(CHUNK_WORDS)) ? 8'(CHUNK_WORDS) : words_left[7:0];
  assign fifo_free  = CW'(FIFO_DEPTH) - fifo_count;
  assign can_issue  = (credit != '0) && (words_left != '0) && (fifo_free >= CW'(chunk_len));
  assign abort      = read_done || !start;
  assign acked      = mem.rd_req && mem.rd_ack;
  assign active     = !abort && (state == FETCH || state == REQ || state == XFER);
  assign pop_empty  = read_fifo && fifo_empty;

  // A line advance while a request waits for ack is parked in line_pend and
  // applied at the ack instead of that burst's bookkeeping; otherwise it
  // loads immediately. Chunk credits granted while parked are overwritten.
  assign load_now = active && ((read_next_line && state != REQ) ||
                               (take_ack && (line_pend || read_next_line)));

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    take_ack   = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    credit_nx  = credit;
    case (state)
      IDLE:  if (read_go && start) state_nx = FETCH;
      FETCH: begin
        if (abort) begin
          state_nx   = IDLE;
          fifo_flush = 1'b1;
        end else if (!read_next_line && can_issue) begin
          issue    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (acked) begin
          take_ack = 1'b1;
          state_nx = abort ? DRAIN : XFER;
        end else if (abort) begin
          state_nx   = IDLE;
          fifo_flush = 1'b1;
        end
      end
      XFER: begin
        if (abort) begin
          state_nx = DRAIN;
        end else if (mem.rd_data_valid) begin
          fifo_push = 1'b1;
          if (beats == 8'd1) state_nx = FETCH;
        end
      end
      DRAIN: begin
        if (beats == '0) begin
          state_nx   = IDLE;
          fifo_flush = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (take_ack) credit_nx = credit_nx - 8'd1;
    if (read_next_chunk && credit_nx < CREDIT_MAX) credit_nx = credit_nx + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      mem.rd_req  <= 1'b0;
      mem.rd_addr <= '0;
      mem.rd_len  <= '0;
      row_addr    <= '0;
      cur_addr    <= '0;
      words_left  <= '0;
      credit      <= '0;
      beats       <= '0;
      line_pend   <= 1'b0;
    end else begin
      state <= state_nx;

      if (issue) begin
        mem.rd_req  <= 1'b1;
        mem.rd_addr <= cur_addr;
        mem.rd_len  <= chunk_len;
      end else if (state_nx != REQ) begin
        mem.rd_req <= 1'b0;
      end

      if (take_ack) begin
        beats <= mem.rd_len;
      end else if ((state == XFER || state == DRAIN) && mem.rd_data_valid && beats != '0) begin
        beats <= beats - 8'd1;
      end

      if (state == IDLE) begin
        if (read_go && start) begin
          row_addr   <= frame_base;
          cur_addr   <= frame_base;
          words_left <= line_words;
          credit     <= CREDIT_INIT;
          line_pend  <= 1'b0;
        end
      end else if (active) begin
        if (read_next_line) row_addr <= row_next;
        if (load_now) begin
          cur_addr   <= read_next_line ? row_next : row_addr;
          words_left <= line_words;
          credit     <= CREDIT_INIT;
          line_pend  <= 1'b0;
        end else begin
          if (take_ack) begin
            cur_addr   <= cur_addr + ADDR_W'({mem.rd_len, 2'b00});
            words_left <= words_left - 11'(mem.rd_len);
          end
          if (state == REQ && read_next_line) line_pend <= 1'b1;
          credit <= credit_nx;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || read_go) underflow <= 1'b0;
    else if (pop_empty)   underflow <= 1'b1;
  end

`ifdef HDMI_FETCH_UNDERFLOW_CNT_EN
  always_ff @(posedge clock) begin
    if (reset || read_go)                     underflow_count <= '0;
    else if (pop_empty && underflow_count != '1) underflow_count <= underflow_count + 16'd1;
  end
`endif

  hdmi_pixel_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .EMPTY_WORD (UNDERFLOW_COLOR)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (mem.rd_data),
    .pop       (read_fifo),
    .head      (color),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_hdmi_pixel_fetch.sv
`timescale 1ns/1ps
module tb_hdmi_pixel_fetch;
  import hdmi_fetch_pkg::*;

  localparam logic [31:0] UCOLOR = 32'h0;

  logic        clock = 1'b0;
  logic        reset, start, num_bytes_per_pixel;
  logic [31:0] frame_base;
  logic [10:0] hres;
  logic        read_go, read_next_line, read_next_chunk, read_done, read_fifo;
  logic [31:0] color;
  logic        underflow;
`ifdef HDMI_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] underflow_count;
`endif

  always #5 clock = ~clock;

  hdmi_pixel_fetch_if #(.ADDR_W(32)) mem ();

  hdmi_pixel_fetch #(
    .FIFO_DEPTH(256), .CHUNK_WORDS(64), .PREFETCH_CHUNKS(2), .ADDR_W(32), .UNDERFLOW_COLOR(UCOLOR)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .frame_base(frame_base), .hres(hres),
    .num_bytes_per_pixel(num_bytes_per_pixel), .read_go(read_go), .read_next_line(read_next_line),
    .read_next_chunk(read_next_chunk), .read_done(read_done), .read_fifo(read_fifo),
    .color(color), .mem(mem), .underflow(underflow)
`ifdef HDMI_FETCH_UNDERFLOW_CNT_EN
    , .underflow_count(underflow_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } burst_t;
  burst_t      exp_burst_q[$];
  logic [31:0] exp_word_q[$];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic expect_burst(input logic [31:0] a, input logic [7:0] l);
    burst_t b;
    b.addr = a;
    b.len  = l;
    exp_burst_q.push_back(b);
  endtask

  // Memory model: acks one cycle after a request, then streams beats.
  int          beats_left = 0;
  int          beat_cnt = 0;
  logic [31:0] beat_addr;
  bit          mem_hold = 0;
  bit          keep_beats = 1;
  initial begin
    mem.rd_ack = 1'b0; mem.rd_data_valid = 1'b0; mem.rd_data = '0;
    forever begin
      @(negedge clock);
      mem.rd_ack = 1'b0;
      mem.rd_data_valid = 1'b0;
      if (reset) begin
        beats_left = 0;
      end else if (beats_left > 0) begin
        mem.rd_data_valid = 1'b1;
        mem.rd_data = pat(beat_addr);
        if (keep_beats) exp_word_q.push_back(pat(beat_addr));
        beat_addr += 4;
        beats_left--;
        beat_cnt++;
      end else if (mem.rd_req && !mem_hold) begin
        mem.rd_ack = 1'b1;
        check("burst_expected", 64'(exp_burst_q.size() != 0), 64'd1);
        if (exp_burst_q.size() != 0) begin
          burst_t b;
          b = exp_burst_q.pop_front();
          check("burst_addr", mem.rd_addr, b.addr);
          check("burst_len", mem.rd_len, b.len);
        end
        beats_left = int'(mem.rd_len);
        beat_addr = mem.rd_addr;
      end
    end
  end

  // HDMI core model: pops and compares the FIFO head against the scoreboard.
  bit pop_en = 0;
  bit drain = 0;
  int empty_pop_req = 0;
  int empty_pop_done = 0;
  initial begin
    read_fifo = 1'b0;
    forever begin
      @(negedge clock);
      read_fifo = 1'b0;
      if (empty_pop_done < empty_pop_req) begin
        read_fifo = 1'b1;
        empty_pop_done++;
      end else if (pop_en && exp_word_q.size() >= (drain ? 1 : 3)) begin
        check("color", color, exp_word_q.pop_front());
        read_fifo = 1'b1;
      end
    end
  end

  bit overflow_seen = 0;
  always @(negedge clock)
    if (dut.fifo_push && dut.u_fifo.mem_count == 9'd256) overflow_seen = 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drain_words();
    drain = 1;
    for (int i = 0; i < 20 && exp_word_q.size() != 0; i++) tick(1);
    tick(2);
    drain = 0;
  endtask

  initial begin
    int b0;
    reset = 1; start = 0; frame_base = '0; hres = '0; num_bytes_per_pixel = 0;
    read_go = 0; read_next_line = 0; read_next_chunk = 0; read_done = 0;
    tick(3);
    check("rst_rd_req", mem.rd_req, 0);
    check("rst_rd_addr", mem.rd_addr, 0);
    check("rst_rd_len", mem.rd_len, 0);
    check("rst_underflow", underflow, 0);
    check("rst_color", color, UCOLOR);
    check("rst_state", dut.state, IDLE);
    reset = 0;
    tick(1);

    // RGB888 line: two prefetch bursts, a third after one chunk credit.
    start = 1; num_bytes_per_pixel = 1; hres = 11'd800; frame_base = 32'h1000_0000; pop_en = 1;
    expect_burst(32'h1000_0000, 8'd64);
    expect_burst(32'h1000_0100, 8'd64);
    read_go = 1; tick(1); read_go = 0;
    tick(200);
    check("t1_prefetch_done", exp_burst_q.size(), 0);
    expect_burst(32'h1000_0200, 8'd64);
    read_next_chunk = 1; tick(1); read_next_chunk = 0;
    tick(100);
    check("t1_chunk_done", exp_burst_q.size(), 0);
    drain_words();
    check("t1_words_left", exp_word_q.size(), 0);
    read_done = 1; tick(1); read_done = 0;
    tick(2);
    check("t1_idle", dut.state, IDLE);

    // Empty pops: underflow color, sticky flag.
    empty_pop_req = empty_pop_done + 5;
    tick(8);
    check("t3_color", color, UCOLOR);
    check("t3_underflow", underflow, 1);
`ifdef HDMI_FETCH_UNDERFLOW_CNT_EN
    check("t3_underflow_count", underflow_count, 5);
`endif

    // RGB565 line of 400 words: 6x64 + 16, then line advances.
    num_bytes_per_pixel = 0; frame_base = 32'h2000_0000;
    for (int i = 0; i < 6; i++) expect_burst(32'h2000_0000 + 32'(i * 256), 8'd64);
    expect_burst(32'h2000_0600, 8'd16);
    read_go = 1; tick(1); read_go = 0;
    tick(1);
    check("t2_underflow_clr", underflow, 0);
    for (int i = 0; i < 5; i++) begin
      tick(40);
      read_next_chunk = 1; tick(1); read_next_chunk = 0;
    end
    tick(300);
    check("t2_line_done", exp_burst_q.size(), 0);
    expect_burst(32'h2000_0640, 8'd64);
    expect_burst(32'h2000_0740, 8'd64);
    read_next_line = 1; tick(1); read_next_line = 0;
    tick(200);
    check("t2_next_line", exp_burst_q.size(), 0);

    // Line and chunk strobes together: chunk credit is lost.
    expect_burst(32'h2000_0C80, 8'd64);
    expect_burst(32'h2000_0D80, 8'd64);
    read_next_line = 1; read_next_chunk = 1; tick(1);
    read_next_line = 0; read_next_chunk = 0;
    check("t5_credit", dut.credit, 2);
    tick(250);
    check("t5_bursts", exp_burst_q.size(), 0);
    drain_words();
    check("t5_words_left", exp_word_q.size(), 0);
    read_done = 1; tick(1); read_done = 0;
    tick(2);

    // read_done mid-burst: remaining beats discarded, FIFO flushed.
    pop_en = 0; keep_beats = 0; num_bytes_per_pixel = 1; frame_base = 32'h3000_0000;
    expect_burst(32'h3000_0000, 8'd64);
    b0 = beat_cnt;
    read_go = 1; tick(1); read_go = 0;
    for (int i = 0; i < 200 && (beat_cnt - b0) < 40; i++) tick(1);
    check("t4_beats_reached", 64'((beat_cnt - b0) >= 40), 64'd1);
    read_done = 1; tick(1); read_done = 0;
    check("t4_drain", dut.state, DRAIN);
    for (int i = 0; i < 100 && beats_left > 0; i++) tick(1);
    tick(3);
    check("t4_beats_total", beat_cnt - b0, 64);
    check("t4_idle", dut.state, IDLE);
    check("t4_fifo_empty", dut.fifo_count, 0);
    check("t4_color", color, UCOLOR);
    check("t4_no_req", mem.rd_req, 0);
    check("t4_no_second_burst", exp_burst_q.size(), 0);

    // Reset while a request waits for ack.
    mem_hold = 1; frame_base = 32'h4000_0000;
    read_go = 1; tick(1); read_go = 0;
    tick(3);
    check("t6_req", mem.rd_req, 1);
    check("t6_addr", mem.rd_addr, 32'h4000_0000);
    check("t6_len", mem.rd_len, 64);
    check("t6_state_req", dut.state, REQ);
    reset = 1; tick(1); reset = 0;
    check("t6_rd_req", mem.rd_req, 0);
    check("t6_state", dut.state, IDLE);
    check("t6_fifo_empty", dut.fifo_count, 0);
    check("t6_color", color, UCOLOR);
    check("t6_rd_addr", mem.rd_addr, 0);
    check("t6_rd_len", mem.rd_len, 0);
    mem_hold = 0;
    tick(2);

    check("no_overflow", 64'(overflow_seen), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
